pzcorebus_request_arbiter: RTL and testbench

//  Round-robin arbiter merging N pzcorebus request ports (command + write-data channels)

---
 rtl/pzcorebus_request_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pzcorebus_request_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_request_arbiter.sv
// Round-robin merge of N pzcorebus request ports onto one downstream port.
// Write data follows its command in grant order through a small index FIFO.
module pzcorebus_request_arbiter #(
  parameter int REQUESTS         = 4,
  parameter int COMMAND_WIDTH    = 128,
  parameter int WRITE_DATA_WIDTH = 73,
  parameter int WRITE_DATA       = 1,
  parameter int INDEX_FIFO_DEPTH = 4
)(
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [REQUESTS-1:0]                  i_mcmd_valid,
  output logic [REQUESTS-1:0]                  o_scmd_accept,
  input  logic [REQUESTS*COMMAND_WIDTH-1:0]    i_mcmd,
  input  logic [REQUESTS-1:0]                  i_mdata_valid,
  output logic [REQUESTS-1:0]                  o_sdata_accept,
  input  logic [REQUESTS*WRITE_DATA_WIDTH-1:0] i_mdata,
  output logic                                 o_mcmd_valid,
  input  logic                                 i_scmd_accept,
  output logic [COMMAND_WIDTH-1:0]             o_mcmd,
  output logic                                 o_mdata_valid,
  input  logic                                 i_sdata_accept,
  output logic [WRITE_DATA_WIDTH-1:0]          o_mdata,
  output logic [$clog2(REQUESTS)-1:0]          o_grant
);

  localparam int CW    = COMMAND_WIDTH;
  localparam int WDW   = WRITE_DATA_WIDTH;
  localparam int IW    = $clog2(REQUESTS);
  localparam int DEPTH = INDEX_FIFO_DEPTH;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic [CW-1:0]       cmd_arr  [REQUESTS];
  logic [WDW-1:0]      data_arr [REQUESTS];
  logic [REQUESTS-1:0] with_data;

  for (genvar k = 0; k < REQUESTS; k++) begin : g_unpack
    assign cmd_arr[k]   = i_mcmd[k*CW +: CW];
    assign data_arr[k]  = i_mdata[k*WDW +: WDW];
    assign with_data[k] = i_mcmd[k*CW + CW - 2];
  end

  logic [IW-1:0]       ptr_q, ptr_d;
  logic                lock_q, lock_d;
  logic [IW-1:0]       lock_idx_q, lock_idx_d;
  logic [REQUESTS-1:0] eligible;
  logic [IW:0]         sum;
  logic [IW-1:0]       idx, sel, grant;
  logic                found, cmd_valid, cmd_hs;
  logic                fifo_full, push;

  // Rotating priority search; a stalled command is held by the lock.
  always_comb begin
    eligible = '0;
    found    = 1'b0;
    sel      = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < REQUESTS; k++)
      eligible[k] = i_mcmd_valid[k] && !(with_data[k] && fifo_full);
    for (int i = 0; i < REQUESTS; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(REQUESTS)) sum = sum - (IW+1)'(REQUESTS);
      idx = sum[IW-1:0];
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    if (lock_q) begin
      grant     = lock_idx_q;
      cmd_valid = i_rst_n && i_mcmd_valid[lock_idx_q];
    end else begin
      grant     = sel;
      cmd_valid = i_rst_n && found;
    end
  end

  assign cmd_hs = cmd_valid && i_scmd_accept;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = cmd_valid && !i_scmd_accept;
    lock_idx_d = lock_d ? grant : lock_idx_q;
    if (cmd_hs) ptr_d = (grant == IW'(REQUESTS - 1)) ? '0 : grant + IW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign o_mcmd_valid = cmd_valid;
  assign o_mcmd       = cmd_valid ? cmd_arr[grant] : '0;
  assign o_grant      = cmd_valid ? grant : '0;

  always_comb begin
    o_scmd_accept = '0;
    if (cmd_hs) o_scmd_accept[grant] = 1'b1;
  end

  if (WRITE_DATA != 0) begin : g_data
    logic [IW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            empty, active, pop;
    logic [IW-1:0]   head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full = (cnt_q == CNTW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign push      = cmd_hs && with_data[grant];
    // On an empty FIFO the command being pushed this cycle steers data directly.
    assign head      = empty ? grant : fifo_mem[rd_q];
    assign active    = i_rst_n && (!empty || push);
    assign pop       = active && i_mdata_valid[head] && i_sdata_accept && data_arr[head][0];

    always_comb begin
      rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
      wr_d  = push ? ptr_inc(wr_q) : wr_q;
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
      else if (!push && pop) cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_q] <= grant;
    end

    assign o_mdata_valid = active && i_mdata_valid[head];
    assign o_mdata       = o_mdata_valid ? data_arr[head] : '0;

    always_comb begin
      o_sdata_accept = '0;
      if (active) o_sdata_accept[head] = i_sdata_accept;
    end

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) push |-> !fifo_full);
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n) pop |-> (!empty || push));
  end else begin : g_no_data
    assign fifo_full      = 1'b0;
    assign push           = 1'b0;
    assign o_mdata_valid  = 1'b0;
    assign o_mdata        = '0;
    assign o_sdata_accept = '0;
  end

  a_lock_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    lock_q |-> (o_mcmd == $past(o_mcmd)));

endmodule

// File: tb/tb_pzcorebus_request_arbiter.sv
// Directed bench for pzcorebus_request_arbiter: arbitration order, lock,
// write-data ordering, FIFO full masking, bypass and asynchronous reset.
module tb_pzcorebus_request_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   mv, scmd_acc, dv, sdata_acc;
  logic [511:0] mcmd;
  logic [291:0] mdata;
  logic         mcmd_valid_o, scmd_accept_i, mdata_valid_o, sdata_accept_i;
  logic [127:0] mcmd_o;
  logic [72:0]  mdata_o;
  logic [1:0]   grant_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pzcorebus_request_arbiter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mcmd_valid   (mv),
    .o_scmd_accept  (scmd_acc),
    .i_mcmd         (mcmd),
    .i_mdata_valid  (dv),
    .o_sdata_accept (sdata_acc),
    .i_mdata        (mdata),
    .o_mcmd_valid   (mcmd_valid_o),
    .i_scmd_accept  (scmd_accept_i),
    .o_mcmd         (mcmd_o),
    .o_mdata_valid  (mdata_valid_o),
    .i_sdata_accept (sdata_accept_i),
    .o_mdata        (mdata_o),
    .o_grant        (grant_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] cmdv(input bit wr, input int tag);
    return {(wr ? 4'b0101 : 4'b0001), 124'(tag)};
  endfunction

  function automatic logic [72:0] datv(input int tag, input bit last);
    return {72'(tag), last};
  endfunction

  task automatic set_cmd(input int p, input bit wr, input int tag);
    mcmd[p*128 +: 128] = cmdv(wr, tag);
    mv[p] = 1'b1;
  endtask

  task automatic set_dat(input int p, input int tag, input bit last);
    mdata[p*73 +: 73] = datv(tag, last);
    dv[p] = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    #1;
  endtask

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return one << p;
  endfunction

  int exp_g1 [5] = '{0, 1, 2, 3, 0};
  int exp_g4 [4] = '{1, 2, 3, 1};
  int exp_h4 [4] = '{2, 3, 1, 1};

  initial begin
    rst_n = 1'b0; mv = '0; dv = '0; mcmd = '0; mdata = '0;
    scmd_accept_i = 1'b0; sdata_accept_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mcmd_valid", mcmd_valid_o, 0);
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_mdata_valid", mdata_valid_o, 0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // 1: all reads, continuous accept -> round robin
    for (int p = 0; p < 4; p++) set_cmd(p, 1'b0, 16 + p);
    scmd_accept_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look;
      check_eq("t1_grant", grant_o, exp_g1[i]);
      check_eq("t1_mcmd", mcmd_o, cmdv(1'b0, 16 + exp_g1[i]));
      check_eq("t1_accept", scmd_acc, onehot(exp_g1[i]));
      tick;
    end
    mv = '0;
    set_cmd(3, 1'b0, 33);
    look;
    check_eq("t1b_grant", grant_o, 3);
    tick;
    mv = '0;

    // 2: stalled port2 holds grant while port0 rises
    scmd_accept_i = 1'b0;
    set_cmd(2, 1'b0, 42);
    look;
    check_eq("t2_grant_c0", grant_o, 2);
    check_eq("t2_accept_c0", scmd_acc, 4'b0000);
    tick;
    set_cmd(0, 1'b0, 40);
    look;
    check_eq("t2_grant_c1", grant_o, 2);
    check_eq("t2_mcmd_c1", mcmd_o, cmdv(1'b0, 42));
    tick;
    look;
    check_eq("t2_grant_c2", grant_o, 2);
    tick;
    scmd_accept_i = 1'b1;
    look;
    check_eq("t2_grant_c3", grant_o, 2);
    check_eq("t2_accept_c3", scmd_acc, 4'b0100);
    tick;
    mv[2] = 1'b0;
    look;
    check_eq("t2_grant_after", grant_o, 0);
    check_eq("t2_accept_after", scmd_acc, 4'b0001);
    tick;
    mv = '0;

    // 3: port1 write len4 then port3 write len2
    set_cmd(1, 1'b1, 49);
    look;
    check_eq("t3_grant_w1", grant_o, 1);
    check_eq("t3_mdata_valid_nodata", mdata_valid_o, 0);
    tick;
    mv = '0;
    set_cmd(3, 1'b1, 51);
    look;
    check_eq("t3_grant_w3", grant_o, 3);
    tick;
    mv = '0;
    sdata_accept_i = 1'b1;
    set_dat(3, 'h300, 1'b0);
    for (int b = 0; b < 4; b++) begin
      set_dat(1, 'h100 + b, b == 3);
      look;
      check_eq("t3_p1_valid", mdata_valid_o, 1);
      check_eq("t3_p1_data", mdata_o, datv('h100 + b, b == 3));
      check_eq("t3_p1_accept", sdata_acc, 4'b0010);
      tick;
    end
    for (int b = 0; b < 2; b++) begin
      set_dat(3, 'h300 + b, b == 1);
      look;
      check_eq("t3_p3_data", mdata_o, datv('h300 + b, b == 1));
      check_eq("t3_p3_accept", sdata_acc, 4'b1000);
      tick;
    end
    look;
    check_eq("t3_empty_valid", mdata_valid_o, 0);
    check_eq("t3_empty_accept", sdata_acc, 4'b0000);
    dv = '0; sdata_accept_i = 1'b0;
    tick;

    // 4: FIFO full masks writes, read still granted, pop reopens
    for (int p = 1; p < 4; p++) set_cmd(p, 1'b1, 64 + p);
    for (int i = 0; i < 4; i++) begin
      look;
      check_eq("t4_fill_grant", grant_o, exp_g4[i]);
      tick;
    end
    set_cmd(0, 1'b0, 64);
    look;
    check_eq("t4_read_valid", mcmd_valid_o, 1);
    check_eq("t4_read_grant", grant_o, 0);
    check_eq("t4_read_mcmd", mcmd_o, cmdv(1'b0, 64));
    tick;
    mv[0] = 1'b0;
    look;
    check_eq("t4_full_masked", mcmd_valid_o, 0);
    sdata_accept_i = 1'b1;
    set_dat(1, 'h400, 1'b1);
    look;
    check_eq("t4_pop_valid", mdata_valid_o, 1);
    check_eq("t4_pop_accept", sdata_acc, 4'b0010);
    tick;
    dv = '0;
    look;
    check_eq("t4_reopen_valid", mcmd_valid_o, 1);
    check_eq("t4_reopen_grant", grant_o, 1);
    tick;
    mv = '0;
    for (int p = 0; p < 4; p++) set_dat(p, 'h480 + p, 1'b1);
    for (int i = 0; i < 4; i++) begin
      look;
      check_eq("t4_drain_head", sdata_acc, onehot(exp_h4[i]));
      tick;
    end
    look;
    check_eq("t4_drained", mdata_valid_o, 0);
    dv = '0;
    tick;

    // 5: command and first beat in the same cycle on an empty FIFO
    set_cmd(2, 1'b1, 80);
    set_dat(2, 'h500, 1'b0);
    look;
    check_eq("t5_grant", grant_o, 2);
    check_eq("t5_bypass_valid", mdata_valid_o, 1);
    check_eq("t5_bypass_data", mdata_o, datv('h500, 1'b0));
    check_eq("t5_bypass_accept", sdata_acc, 4'b0100);
    tick;
    mv = '0;
    set_dat(2, 'h501, 1'b1);
    look;
    check_eq("t5_last_data", mdata_o, datv('h501, 1'b1));
    tick;
    dv = '0;
    look;
    check_eq("t5_empty", mdata_valid_o, 0);
    tick;

    // 6: asynchronous reset in the middle of a burst and a locked command
    set_cmd(3, 1'b1, 96);
    look;
    check_eq("t6_grant_w3", grant_o, 3);
    tick;
    mv = '0;
    set_dat(3, 'h600, 1'b0);
    set_cmd(1, 1'b0, 97);
    look;
    check_eq("t6_data_valid", mdata_valid_o, 1);
    check_eq("t6_grant_r1", grant_o, 1);
    tick;
    mv = '0;
    scmd_accept_i = 1'b0;
    set_cmd(2, 1'b0, 98);
    set_dat(3, 'h601, 1'b0);
    tick;
    look;
    check_eq("t6_locked_grant", grant_o, 2);
    rst_n = 1'b0;
    look;
    check_eq("t6_rst_mcmd_valid", mcmd_valid_o, 0);
    check_eq("t6_rst_mcmd", mcmd_o, 0);
    check_eq("t6_rst_grant", grant_o, 0);
    check_eq("t6_rst_scmd_acc", scmd_acc, 0);
    check_eq("t6_rst_mdata_valid", mdata_valid_o, 0);
    check_eq("t6_rst_mdata", mdata_o, 0);
    check_eq("t6_rst_sdata_acc", sdata_acc, 0);
    mv = '0; dv = '0; scmd_accept_i = 1'b0; sdata_accept_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
    for (int p = 0; p < 4; p++) set_cmd(p, 1'b0, 112 + p);
    set_dat(3, 'h602, 1'b0);
    scmd_accept_i = 1'b1;
    sdata_accept_i = 1'b1;
    look;
    check_eq("t6_ptr_zero_grant", grant_o, 0);
    check_eq("t6_fifo_cleared", mdata_valid_o, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
